// File: rtl/m2_pkg.sv
// rtl/m2_pkg.sv - shared types, plane encodings and sample helpers for the Milestone 2 IDCT pipeline
package m2_pkg;

    typedef enum logic [1:0] {
        S_WS_IDLE     = 2'd0,
        S_WS_READ     = 2'd1,
        S_WS_LEAD_OUT = 2'd2,
        S_WS_DONE     = 2'd3
    } ws_state_type;

    localparam logic [1:0] PLANE_Y       = 2'd0;
    localparam logic [1:0] PLANE_U       = 2'd1;
    localparam logic [1:0] PLANE_V       = 2'd2;
    localparam logic [1:0] PLANE_ILLEGAL = 2'd3;

    localparam int Y_WIDTH_WORDS  = 160;
    localparam int UV_WIDTH_WORDS = 80;
    localparam int BLOCK_WORDS    = 32;

    // Saturate a signed 32-bit reconstructed sample into the 0..255 pixel range.
    function automatic logic [7:0] clip_sample(input logic [31:0] value);
        logic [7:0] result;
        if (value[31])
            result = 8'd0;
        else if (|value[30:8])
            result = 8'd255;
        else
            result = value[7:0];
        return result;
    endfunction

    function automatic logic sample_is_clipped(input logic [31:0] value);
        return value[31] | (|value[30:8]);
    endfunction

endpackage

// File: rtl/m2_ws_addr_gen.sv
// rtl/m2_ws_addr_gen.sv - SRAM word address of one packed word of an 8x8 block
// Ports:
//   plane        in  2   0=Y, 1=U, 2=V, 3=illegal (addressed like Y)
//   block_col    in  6   block column
//   block_row    in  5   block row
//   word_index   in  5   packed word j within the block (row j/4, column j%4)
//   address      out 18  BASE + (8*row + j/4)*W + 4*col + j%4, modulo 2^18
module m2_ws_addr_gen
    import m2_pkg::*;
#(
    parameter logic [17:0] Y_BASE = 18'd0,
    parameter logic [17:0] U_BASE = 18'd38400,
    parameter logic [17:0] V_BASE = 18'd57600
) (
    input  logic [1:0]  plane,
    input  logic [5:0]  block_col,
    input  logic [4:0]  block_row,
    input  logic [4:0]  word_index,
    output logic [17:0] address
);

    logic [17:0] base;
    logic [17:0] width;
    logic [7:0]  row_term;
    logic [7:0]  col_term;
    logic [17:0] row_offset;

    always_comb begin
        base  = Y_BASE;
        width = 18'(Y_WIDTH_WORDS);
        case (plane)
            PLANE_U: begin
                base  = U_BASE;
                width = 18'(UV_WIDTH_WORDS);
            end
            PLANE_V: begin
                base  = V_BASE;
                width = 18'(UV_WIDTH_WORDS);
            end
            default: begin
                base  = Y_BASE;
                width = 18'(Y_WIDTH_WORDS);
            end
        endcase

        // Sample row within the plane and word column within the SRAM line;
        // both fit in 8 bits for any 5-bit row / 6-bit column.
        row_term   = {block_row, 3'b000} + {5'd0, word_index[4:2]};
        col_term   = {block_col, 2'b00} + {6'd0, word_index[1:0]};
        row_offset = {10'd0, row_term} * width;
        address    = base + row_offset + {10'd0, col_term};
    end

endmodule

// File: rtl/m2_ws_writer.sv
// rtl/m2_ws_writer.sv - Write-S stage: clip, pack and store one 8x8 block of S samples to SRAM
// Optional feature macro: WS_CLIP_COUNT_EN (adds WS_clip_count).
// Ports:
//   CLOCK_50_I        in  1   system clock
//   Resetn            in  1   asynchronous active-low reset
//   WS_start          in  1   start one block, sampled in S_WS_IDLE only
//   WS_plane          in  2   0=Y, 1=U, 2=V, 3=illegal (no SRAM writes)
//   WS_block_col      in  6   block column
//   WS_block_row      in  5   block row
//   WS_busy           out 1   block in progress, through the done cycle
//   WS_done           out 1   one-cycle completion pulse
//   RAM_read_address  out 7   DP-RAM port-a address
//   RAM_read_data     in  32  signed S sample, one cycle after its address
//   SRAM_address      out 18  SRAM word address
//   SRAM_write_data   out 16  two clipped samples, even in [15:8]
//   SRAM_we_n         out 1   active-low SRAM write enable
//   WS_clip_count     out 7   samples clipped in the current block (WS_CLIP_COUNT_EN only)
module m2_ws_writer
    import m2_pkg::*;
#(
    parameter logic [17:0] Y_BASE = 18'd0,
    parameter logic [17:0] U_BASE = 18'd38400,
    parameter logic [17:0] V_BASE = 18'd57600
) (
    input  logic        CLOCK_50_I,
    input  logic        Resetn,
    input  logic        WS_start,
    input  logic [1:0]  WS_plane,
    input  logic [5:0]  WS_block_col,
    input  logic [4:0]  WS_block_row,
    output logic        WS_busy,
    output logic        WS_done,
    output logic [6:0]  RAM_read_address,
    input  logic [31:0] RAM_read_data,
    output logic [17:0] SRAM_address,
    output logic [15:0] SRAM_write_data,
    output logic        SRAM_we_n
`ifdef WS_CLIP_COUNT_EN
    ,
    output logic [6:0]  WS_clip_count
`endif
);

    ws_state_type ws_state;
    ws_state_type ws_state_next;

    logic        start_accept;
    logic        last_read;
    logic        lead_cnt;

    logic [1:0]  plane_q;
    logic [5:0]  col_q;
    logic [4:0]  row_q;

    // Tracks which sample RAM_read_data carries this cycle.
    logic        data_valid;
    logic [5:0]  data_index;

    logic [7:0]  even_byte;
    logic [7:0]  clipped_byte;
    logic [17:0] word_address;

    assign clipped_byte = clip_sample(RAM_read_data);
    assign last_read    = (RAM_read_address == 7'd63);

    m2_ws_addr_gen #(
        .Y_BASE (Y_BASE),
        .U_BASE (U_BASE),
        .V_BASE (V_BASE)
    ) u_addr_gen (
        .plane      (plane_q),
        .block_col  (col_q),
        .block_row  (row_q),
        .word_index (data_index[5:1]),
        .address    (word_address)
    );

    always_ff @(posedge CLOCK_50_I or negedge Resetn) begin
        if (!Resetn)
            ws_state <= S_WS_IDLE;
        else
            ws_state <= ws_state_next;
    end

    always_comb begin
        ws_state_next = ws_state;
        start_accept  = 1'b0;
        WS_busy       = 1'b1;
        WS_done       = 1'b0;
        case (ws_state)
            S_WS_IDLE: begin
                WS_busy = 1'b0;
                if (WS_start) begin
                    start_accept  = 1'b1;
                    ws_state_next = S_WS_READ;
                end
            end
            S_WS_READ: begin
                if (last_read)
                    ws_state_next = S_WS_LEAD_OUT;
            end
            S_WS_LEAD_OUT: begin
                // Two cycles: one for the last RAM read to land, one to
                // register the final SRAM write.
                if (lead_cnt)
                    ws_state_next = S_WS_DONE;
            end
            S_WS_DONE: begin
                WS_done       = 1'b1;
                ws_state_next = S_WS_IDLE;
            end
            default: begin
                ws_state_next = S_WS_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50_I or negedge Resetn) begin
        if (!Resetn) begin
            plane_q          <= PLANE_Y;
            col_q            <= 6'd0;
            row_q            <= 5'd0;
            RAM_read_address <= 7'd0;
            lead_cnt         <= 1'b0;
            data_valid       <= 1'b0;
            data_index       <= 6'd0;
            even_byte        <= 8'd0;
            SRAM_address     <= 18'd0;
            SRAM_write_data  <= 16'd0;
            SRAM_we_n        <= 1'b1;
        end else begin
            if (start_accept) begin
                plane_q          <= WS_plane;
                col_q            <= WS_block_col;
                row_q            <= WS_block_row;
                RAM_read_address <= 7'd0;
            end else if (ws_state == S_WS_READ && !last_read) begin
                RAM_read_address <= RAM_read_address + 7'd1;
            end

            lead_cnt   <= (ws_state == S_WS_LEAD_OUT) ? ~lead_cnt : 1'b0;
            data_valid <= (ws_state == S_WS_READ);
            data_index <= RAM_read_address[5:0];

            if (data_valid && !data_index[0])
                even_byte <= clipped_byte;

            // The odd sample completes a word; the illegal plane runs the
            // full sequence but never asserts the write strobe.
            if (data_valid && data_index[0]) begin
                SRAM_address    <= word_address;
                SRAM_write_data <= {even_byte, clipped_byte};
                SRAM_we_n       <= (plane_q == PLANE_ILLEGAL);
            end else begin
                SRAM_we_n       <= 1'b1;
            end
        end
    end

`ifdef WS_CLIP_COUNT_EN
    always_ff @(posedge CLOCK_50_I or negedge Resetn) begin
        if (!Resetn)
            WS_clip_count <= 7'd0;
        else if (start_accept)
            WS_clip_count <= 7'd0;
        else if (data_valid && sample_is_clipped(RAM_read_data))
            WS_clip_count <= WS_clip_count + 7'd1;
    end
`endif

endmodule

// File: tb/tb_m2_ws_writer.sv
// tb/tb_m2_ws_writer.sv - directed self-checking bench for m2_ws_writer
module tb_m2_ws_writer;

    logic        CLOCK_50_I;
    logic        Resetn;
    logic        WS_start;
    logic [1:0]  WS_plane;
    logic [5:0]  WS_block_col;
    logic [4:0]  WS_block_row;
    logic        WS_busy;
    logic        WS_done;
    logic [6:0]  RAM_read_address;
    logic [31:0] RAM_read_data;
    logic [17:0] SRAM_address;
    logic [15:0] SRAM_write_data;
    logic        SRAM_we_n;
`ifdef WS_CLIP_COUNT_EN
    logic [6:0]  WS_clip_count;
`endif

    m2_ws_writer dut (
        .CLOCK_50_I       (CLOCK_50_I),
        .Resetn           (Resetn),
        .WS_start         (WS_start),
        .WS_plane         (WS_plane),
        .WS_block_col     (WS_block_col),
        .WS_block_row     (WS_block_row),
        .WS_busy          (WS_busy),
        .WS_done          (WS_done),
        .RAM_read_address (RAM_read_address),
        .RAM_read_data    (RAM_read_data),
        .SRAM_address     (SRAM_address),
        .SRAM_write_data  (SRAM_write_data),
        .SRAM_we_n        (SRAM_we_n)
`ifdef WS_CLIP_COUNT_EN
        ,
        .WS_clip_count    (WS_clip_count)
`endif
    );

    initial CLOCK_50_I = 1'b0;
    always #10 CLOCK_50_I = ~CLOCK_50_I;

    logic [31:0] ram [0:127];
    always @(posedge CLOCK_50_I) RAM_read_data <= ram[RAM_read_address];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // Per-run capture
    logic [17:0] wr_addr [32];
    logic [15:0] wr_data [32];
    int          wr_cyc  [32];
    int          wr_cnt;
    int          done_cnt;
    int          done_cyc;
    logic        busy_c1;
    logic        busy_c67;
    logic        busy_c68;
    logic [17:0] max_addr;

    function automatic logic [17:0] exp_addr(input logic [1:0] plane, input int col, input int row, input int j);
        int base;
        int w;
        case (plane)
            2'd1:    begin base = 38400; w = 80;  end
            2'd2:    begin base = 57600; w = 80;  end
            default: begin base = 0;     w = 160; end
        endcase
        return 18'(base + (8 * row + j / 4) * w + 4 * col + j % 4);
    endfunction

    // Caller is at a falling edge: that clock period is cycle 0.
    task automatic run_block(input logic [1:0] plane, input logic [5:0] col, input logic [4:0] row,
                             input int start_len, input int abort_at);
        WS_plane     = plane;
        WS_block_col = col;
        WS_block_row = row;
        WS_start     = 1'b1;
        wr_cnt   = 0;
        done_cnt = 0;
        done_cyc = -1;
        busy_c1  = 1'b0;
        busy_c67 = 1'b0;
        busy_c68 = 1'b1;
        max_addr = 18'd0;
        for (int cyc = 1; cyc <= 68; cyc++) begin
            @(negedge CLOCK_50_I);
            if (cyc == abort_at) begin
                Resetn = 1'b0;
                #1;
                check_val("abort_ram_addr",  32'(RAM_read_address), 32'd0);
                check_val("abort_sram_addr", 32'(SRAM_address),     32'd0);
                check_val("abort_sram_data", 32'(SRAM_write_data),  32'd0);
                check_val("abort_we_n",      32'(SRAM_we_n),        32'd1);
                check_val("abort_busy",      32'(WS_busy),          32'd0);
            end
            if (cyc == start_len) WS_start = 1'b0;
            if (!SRAM_we_n) begin
                if (wr_cnt < 32) begin
                    wr_addr[wr_cnt] = SRAM_address;
                    wr_data[wr_cnt] = SRAM_write_data;
                    wr_cyc[wr_cnt]  = cyc;
                end
                if (SRAM_address > max_addr) max_addr = SRAM_address;
                wr_cnt++;
            end
            if (WS_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (cyc == 1)  busy_c1  = WS_busy;
            if (cyc == 67) busy_c67 = WS_busy;
            if (cyc == 68) busy_c68 = WS_busy;
        end
    endtask

    // Expectations for a Y block at col 0 row 0 with RAM[k]=k.
    task automatic verify_y00(input string pfx);
        int bad;
        check_val({pfx, "_wr_cnt"},     32'(wr_cnt),     32'd32);
        check_val({pfx, "_first_cyc"},  32'(wr_cyc[0]),  32'd4);
        check_val({pfx, "_first_addr"}, 32'(wr_addr[0]), 32'd0);
        check_val({pfx, "_first_data"}, 32'(wr_data[0]), 32'h0001);
        check_val({pfx, "_w4_addr"},    32'(wr_addr[4]), 32'd160);
        check_val({pfx, "_w4_data"},    32'(wr_data[4]), 32'h0809);
        check_val({pfx, "_last_cyc"},   32'(wr_cyc[31]), 32'd66);
        check_val({pfx, "_last_addr"},  32'(wr_addr[31]), 32'd1123);
        check_val({pfx, "_last_data"},  32'(wr_data[31]), 32'h3E3F);
        check_val({pfx, "_done_cyc"},   32'(done_cyc),   32'd67);
        check_val({pfx, "_done_cnt"},   32'(done_cnt),   32'd1);
        check_val({pfx, "_busy_c1"},    32'(busy_c1),    32'd1);
        check_val({pfx, "_busy_c67"},   32'(busy_c67),   32'd1);
        check_val({pfx, "_busy_c68"},   32'(busy_c68),   32'd0);
        bad = 0;
        for (int j = 0; j < 32; j++) begin
            if (wr_cyc[j] != 4 + 2 * j) bad++;
            if (wr_addr[j] != exp_addr(2'd0, 0, 0, j)) bad++;
            if (wr_data[j] != {8'(2 * j), 8'(2 * j + 1)}) bad++;
        end
        check_val({pfx, "_all_words_bad"}, 32'(bad), 32'd0);
    endtask

    task automatic load_ordered();
        for (int k = 0; k < 128; k++) ram[k] = 32'(k);
    endtask

    initial begin
        int extra;
        Resetn       = 1'b0;
        WS_start     = 1'b0;
        WS_plane     = 2'd0;
        WS_block_col = 6'd0;
        WS_block_row = 5'd0;
        load_ordered();
        repeat (3) @(negedge CLOCK_50_I);

        // Reset state
        check_val("rst_ram_addr",  32'(RAM_read_address), 32'd0);
        check_val("rst_sram_addr", 32'(SRAM_address),     32'd0);
        check_val("rst_sram_data", 32'(SRAM_write_data),  32'd0);
        check_val("rst_we_n",      32'(SRAM_we_n),        32'd1);
        check_val("rst_busy",      32'(WS_busy),          32'd0);
        check_val("rst_done",      32'(WS_done),          32'd0);
`ifdef WS_CLIP_COUNT_EN
        check_val("rst_clip_count", 32'(WS_clip_count),   32'd0);
`endif
        Resetn = 1'b1;
        @(negedge CLOCK_50_I);

        // Y block, ordered samples
        run_block(2'd0, 6'd0, 5'd0, 1, 0);
        verify_y00("y00");

        // Clipping
        ram[0] = 32'hFFFF_FFFB;
        ram[1] = 32'd300;
        ram[2] = 32'd255;
        ram[3] = 32'd0;
        run_block(2'd0, 6'd0, 5'd0, 1, 0);
        check_val("clip_w0", 32'(wr_data[0]), 32'h00FF);
        check_val("clip_w1", 32'(wr_data[1]), 32'hFF00);
        check_val("clip_w2", 32'(wr_data[2]), 32'h0405);
`ifdef WS_CLIP_COUNT_EN
        check_val("clip_count", 32'(WS_clip_count), 32'd2);
`endif
        load_ordered();

        // U block at the plane edge
        run_block(2'd1, 6'd19, 5'd29, 1, 0);
        check_val("u_edge_cnt",   32'(wr_cnt),      32'd32);
        check_val("u_edge_first", 32'(wr_addr[0]),  32'd57036);
        check_val("u_edge_last",  32'(wr_addr[31]), 32'd57599);
        check_val("u_edge_below_v", 32'(max_addr < 18'd57600), 32'd1);

        // V block
        run_block(2'd2, 6'd1, 5'd0, 1, 0);
        check_val("v_first", 32'(wr_addr[0]), 32'd57604);
        check_val("v_w5",    32'(wr_addr[5]), 32'(exp_addr(2'd2, 1, 0, 5)));

        // Illegal plane
        run_block(2'd3, 6'd0, 5'd0, 1, 0);
        check_val("ill_wr_cnt",   32'(wr_cnt),   32'd0);
        check_val("ill_done_cyc", 32'(done_cyc), 32'd67);
        check_val("ill_busy_c67", 32'(busy_c67), 32'd1);

        // Reset mid-block, then restart
        run_block(2'd0, 6'd0, 5'd0, 1, 20);
        check_val("abort_done_cnt", 32'(done_cnt), 32'd0);
        Resetn = 1'b1;
        @(negedge CLOCK_50_I);
        run_block(2'd0, 6'd0, 5'd0, 1, 0);
        verify_y00("restart");

        // Start held in cycles 0-3: one block only
        run_block(2'd0, 6'd0, 5'd0, 4, 0);
        check_val("held_wr_cnt",   32'(wr_cnt),   32'd32);
        check_val("held_done_cnt", 32'(done_cnt), 32'd1);
        extra = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLOCK_50_I);
            if (!SRAM_we_n || WS_busy || WS_done) extra++;
        end
        check_val("held_no_second_block", 32'(extra), 32'd0);

        // Back-to-back: start in cycle 68 of the previous block
        run_block(2'd0, 6'd0, 5'd0, 1, 0);
        check_val("b2b_first_busy_c68", 32'(busy_c68), 32'd0);
        run_block(2'd0, 6'd0, 5'd0, 1, 0);
        check_val("b2b_first_write_abs", 32'(68 + wr_cyc[0]), 32'd72);
        check_val("b2b_wr_cnt",          32'(wr_cnt),         32'd32);
        check_val("b2b_done_cyc",        32'(done_cyc),       32'd67);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/m2_ws_writer.md
# m2_ws_writer

Write-S stage of the Milestone 2 IDCT pipeline. It drains one 8x8 block of reconstructed samples S from a 32-bit dual-port RAM, clips each sample to 8 bits and packs two samples per 16-bit word. It then writes the 32 words to the Y, U or V region of external SRAM at the block's raster position. It sits downstream of the compute-S stage, and its SRAM output feeds the Milestone 1 upsampling/colour-conversion pass.

## Interface
- Y_BASE, 18'd0, SRAM word address of the Y plane
- U_BASE, 18'd38400, SRAM word address of the U plane
- V_BASE, 18'd57600, SRAM word address of the V plane
- CLOCK_50_I  in  1  system clock, 50 MHz
- Resetn  in  1  reset; asynchronous, active-low
- WS_start  in  1  start one block; sampled only in S_WS_IDLE
- WS_plane  in  2  0=Y, 1=U, 2=V, 3=illegal; latched at start
- WS_block_col  in  6  block column; latched at start
- WS_block_row  in  5  block row; latched at start
- WS_busy  out  1  high from the cycle after start acceptance through the done cycle
- WS_done  out  1  one-cycle pulse when the block is complete
- RAM_read_address  out  7  DP-RAM port-a address; registered
- RAM_read_data  in  32  signed S sample; valid one cycle after its address is presented
- SRAM_address  out  18  registered
- SRAM_write_data  out  16  registered
- SRAM_we_n  out  1  active-low write enable; registered

## Operation
- States: S_WS_IDLE → S_WS_READ (64 cycles) → S_WS_LEAD_OUT (2 cycles) → S_WS_DONE → S_WS_IDLE.
- DP-RAM layout: sample (r,c) is at address 8r+c, row-major.
- Pairing: word j (j=0..31) holds samples 2j and 2j+1.
  - Even sample goes in [15:8], odd sample in [7:0].
  - The even clipped value is held in a byte register until its odd partner arrives.
- Clip rule on the 32-bit signed input:
  - value < 0 → 8'd0
  - value > 255 → 8'd255
  - otherwise [7:0]
- Address of word j, with r=j/4 and c=j%4: BASE + (8·row + r)·W + 4·col + c.
  - W=160 for Y, W=80 for U/V.
  - Computed in 18 bits, modulo 2^18.
  - Block coordinates are not range-checked; the caller owns legality.
- WS_plane=3: full sequence and timing run unchanged, but SRAM_we_n stays 1 throughout.
- WS_start while busy is ignored.
- Reset values: all outputs 0, except SRAM_we_n=1. State goes to S_WS_IDLE.
- Reset mid-block aborts with no WS_done. The next start begins from word 0.

## Timing
- Cycle 0 is the IDLE cycle in which WS_start=1. Coordinates and plane are latched at the end of cycle 0.
- Cycle 1+k: RAM_read_address=k, for k=0..63.
- Cycle 2+k: RAM_read_data holds sample k.
- Cycle 4+2j: SRAM_we_n=0, with SRAM_address and SRAM_write_data for word j.
  - First write is in cycle 4; last write is in cycle 66.
  - SRAM_we_n=1 in every other cycle.
- Cycle 67: WS_done=1, WS_busy=1. Cycle 68: IDLE, where a new WS_start is accepted.
- Fixed latency of 68 cycles start to IDLE; no stalls.
- The SRAM port is owned exclusively by this block between cycles 1 and 67.

## Configuration
- WS_CLIP_COUNT_EN defined:
  - Adds output WS_clip_count [6:0].
  - Counts samples clipped (low or high) in the current block.
  - Cleared in cycle 1 and stable from cycle 67 until the next start.
  - Reset value 0.
- WS_CLIP_COUNT_EN undefined: the port and the counter are absent, and all other behaviour is identical.

## Structure
- Shared package m2_pkg holds:
  - ws_state_type enum
  - plane encoding constants PLANE_Y/PLANE_U/PLANE_V
  - Y_WIDTH_WORDS=160 and UV_WIDTH_WORDS=80
  - BLOCK_WORDS=32
- Sub-module m2_ws_addr_gen: combinational; takes plane, base parameters, latched col/row and word index j, and produces the 18-bit SRAM address.
- Clipping and packing stay inline.

## Test plan
- **Y block, ordered samples:** Y block col=0 row=0, RAM[k]=k.
  - Cycle 4: write 16'h0001 at address 0.
  - Word 4 (16'h0809) is written at address 160.
  - Cycle 66: write 16'h3E3F at address 1123.
  - Cycle 67: WS_done pulses.
- **Clipping:** RAM[0]=-5, RAM[1]=300, RAM[2]=255, RAM[3]=0.
  - Word 0 = 16'h00FF; word 1 = 16'hFF00.
  - With WS_CLIP_COUNT_EN, WS_clip_count=2.
- **U block at the plane edge:** U block col=19 row=29.
  - First write at 57036; last write at 57599.
  - No address reaches V_BASE.
- **V block and illegal plane:** V block col=1 row=0 → first write at 57604. Plane=3 → SRAM_we_n never 0, and WS_done still pulses at cycle 67.
- **Reset mid-block:** Resetn low in cycle 20.
  - Outputs go to reset values immediately, with no WS_done.
  - A restart with the same inputs reproduces scenario 1 exactly.
- **Start handling:**
  - WS_start held high in cycles 0–3 → only one block is processed.
  - WS_start in cycle 68 is accepted, with first write at cycle 72.
